pe_array_seq: RTL and testbench

- Sequencer for an N x N systolic array of int multiply-accumulate PEs. Each PE has a `load_in` strobe, a multiplier with fixed latency, an accumulating `pe_result`, and an active-high synchronous PE reset.
- Clears the array, then steps through the skewed operand wavefront. Per step it fetches operands from the A/B buffers, pulses `load_in`, and holds off for multiplier latency so the accumulation lands.
- Signals completion when every `pe_result` is final.
- Sits between the host command interface and the operand feeder/array.

---
 rtl/pe_array_seq_if.sv | 27 ++
 rtl/pe_array_seq.sv | 131 +++++++++++++
 tb/tb_pe_array_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_seq_if.sv
// Host/feeder handshake bundle for the systolic-array sequencer.
// master = host/feeder side, slave = sequencer side.
interface pe_array_seq_if #(
    parameter int K_W    = 8,
    parameter int STEP_W = 9
);
    logic              start;
    logic [K_W-1:0]    k_len;
    logic              abort;
    logic              buf_rd_en;
    logic [STEP_W-1:0] buf_addr;
    logic              load_in;
    logic              pe_rst;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, k_len, abort,
        input  buf_rd_en, buf_addr, load_in, pe_rst, busy, done, err
    );

    modport slave (
        input  start, k_len, abort,
        output buf_rd_en, buf_addr, load_in, pe_rst, busy, done, err
    );
endinterface

// File: rtl/pe_array_seq.sv
// Wavefront sequencer for an N x N int MAC systolic array.
// Clear, then fetch/feed/wait once per skewed step, then pulse done.
module pe_array_seq #(
    parameter int N       = 4,
    parameter int K_W     = 8,
    parameter int STEP_W  = 9,
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    pe_array_seq_if.slave bus
);
    localparam int WAIT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [STEP_W-1:0] LAST_OFS = STEP_W'(2 * N - 3);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(MUL_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] last_q;
    logic [WAIT_W-1:0] wait_q;
    logic [STEP_W-1:0] addr_q;
    logic              rd_en_q;
    logic              load_q;
    logic              pe_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic [STEP_W-1:0] step_d;
    logic              wait_end_d;
    logic              last_step_d;

    assign step_d      = step_q + STEP_W'(1);
    assign wait_end_d  = (wait_q == WAIT_END);
    assign last_step_d = (step_q == last_q);

    // Outputs are registered: each is set alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            last_q   <= '0;
            wait_q   <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            load_q   <= 1'b0;
            pe_rst_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rd_en_q  <= 1'b0;
            load_q   <= 1'b0;
            pe_rst_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            if (bus.abort && state_q != S_IDLE) begin
                state_q  <= S_IDLE;
                pe_rst_q <= 1'b1;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            if (bus.k_len != '0) begin
                                state_q  <= S_CLEAR;
                                last_q   <= STEP_W'(bus.k_len) + LAST_OFS;
                                step_q   <= '0;
                                pe_rst_q <= 1'b1;
                                busy_q   <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_CLEAR: begin
                        state_q <= S_FETCH;
                        rd_en_q <= 1'b1;
                        addr_q  <= step_q;
                    end
                    S_FETCH: begin
                        state_q <= S_FEED;
                        load_q  <= 1'b1;
                    end
                    S_FEED: begin
                        state_q <= S_WAIT;
                        wait_q  <= '0;
                    end
                    S_WAIT: begin
                        if (!wait_end_d) begin
                            wait_q <= wait_q + WAIT_W'(1);
                        end else if (last_step_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            step_q  <= step_d;
                            addr_q  <= step_d;
                            rd_en_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.buf_rd_en = rd_en_q;
    assign bus.buf_addr  = addr_q;
    assign bus.load_in   = load_q;
    assign bus.pe_rst    = pe_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_pe_array_seq.sv
// Directed bench for pe_array_seq with a behavioural N x N MAC array model.
// The model applies the feeder skew and zero padding to the stepped wavefront.
module tb_pe_array_seq;
    localparam int N       = 4;
    localparam int K_W     = 8;
    localparam int STEP_W  = 9;
    localparam int MUL_LAT = 4;
    localparam int STEP_CY = MUL_LAT + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_array_seq_if #(.K_W(K_W), .STEP_W(STEP_W)) bus ();

    pe_array_seq #(
        .N(N), .K_W(K_W), .STEP_W(STEP_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    int a_val, b_val, kcur;
    int acc [N][N];
    int rd_addr;
    int tcnt      = 0;
    int last_load = -1;
    int run_loads = 0;
    int addr_bad  = 0;
    int gap_bad   = 0;
    int ovl_bad   = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int rst_cnt   = 0;

    // Array and feeder model, sampled mid-cycle.
    always @(negedge clk) begin
        tcnt <= tcnt + 1;
        if (bus.pe_rst) begin
            rst_cnt <= rst_cnt + 1;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] <= 0;
        end
        if (bus.buf_rd_en) rd_addr <= int'(bus.buf_addr);
        if (bus.buf_rd_en && bus.load_in) ovl_bad <= ovl_bad + 1;
        if (bus.load_in) begin
            if (int'(bus.buf_addr) != run_loads) addr_bad <= addr_bad + 1;
            if (last_load >= 0 && tcnt - last_load != STEP_CY)
                gap_bad <= gap_bad + 1;
            last_load <= tcnt;
            run_loads <= run_loads + 1;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (rd_addr - i - j >= 0 && rd_addr - i - j < kcur)
                        acc[i][j] <= acc[i][j] + a_val * b_val;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int res_bad(input int exp);
        int n = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (acc[i][j] != exp) n++;
        return n;
    endfunction

    // Issues a command at a negedge; returns the cycle of done (-1 if none).
    task automatic run(input int k, input int a, input int b,
                       input int restart_step, input int abort_cyc,
                       input int rst_cyc, output int done_cyc);
        int cyc;
        bit fin;
        a_val = a;
        b_val = b;
        kcur = k;
        run_loads = 0;
        last_load = -1;
        addr_bad = 0;
        gap_bad = 0;
        ovl_bad = 0;
        done_cyc = -1;
        fin = 1'b0;
        bus.start = 1'b1;
        bus.k_len = K_W'(k);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            if (cyc == rst_cyc) begin
                chk("rst_feed_load", bus.load_in, 1);
                rst = 1'b0;
                #1;
                chk("rst_load_drop", bus.load_in, 0);
                chk("rst_busy_drop", bus.busy, 0);
                chk("rst_pe_rst", bus.pe_rst, 1);
                fin = 1'b1;
            end else if (bus.done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end else begin
                if (cyc == abort_cyc) bus.abort = 1'b1;
                if (bus.buf_rd_en && int'(bus.buf_addr) == restart_step) begin
                    bus.start = 1'b1;
                    bus.k_len = K_W'(7);
                end
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                if (bus.abort) fin = 1'b1;
                bus.abort = 1'b0;
                cyc++;
            end
        end
    endtask

    int dc, d0, e0, r0;

    initial begin
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.abort = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_pe_rst_hi", bus.pe_rst, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_outs", {bus.buf_rd_en, bus.load_in, bus.done, bus.err}, 0);
        chk("rst_addr", bus.buf_addr, 0);
        rst = 1'b1;
        #1;
        chk("rel_pe_rst_hold", bus.pe_rst, 1);
        @(negedge clk);
        chk("rel_pe_rst_low", bus.pe_rst, 0);
        chk("rel_busy", bus.busy, 0);

        // Basic k_len=3 run: T=9.
        err_cnt = 0;
        run(3, 2, 3, -1, -1, -1, dc);
        chk("k3_done_cyc", dc, 2 + 9 * STEP_CY);
        chk("k3_busy_at_done", bus.busy, 1);
        chk("k3_loads", run_loads, 9);
        chk("k3_addr_seq", addr_bad, 0);
        chk("k3_gap", gap_bad, 0);
        chk("k3_overlap", ovl_bad, 0);
        chk("k3_results", res_bad(18), 0);
        @(negedge clk);
        chk("k3_idle_busy", bus.busy, 0);
        chk("k3_done_pulse", bus.done, 0);
        chk("k3_results_hold", res_bad(18), 0);

        // k_len=0 error pulse.
        r0 = rst_cnt;
        d0 = run_loads;
        bus.start = 1'b1;
        bus.k_len = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("k0_err", bus.err, 1);
        chk("k0_busy", bus.busy, 0);
        @(negedge clk);
        chk("k0_err_once", bus.err, 0);
        chk("k0_busy2", bus.busy, 0);
        chk("k0_no_load", run_loads, d0);
        chk("k0_no_pe_rst", rst_cnt, r0);

        // start while busy is ignored.
        e0 = err_cnt;
        run(3, 2, 3, 4, -1, -1, dc);
        chk("restart_done_cyc", dc, 2 + 9 * STEP_CY);
        chk("restart_loads", run_loads, 9);
        chk("restart_results", res_bad(18), 0);
        chk("restart_no_err", err_cnt, e0);
        @(negedge clk);
        chk("restart_idle", bus.busy, 0);

        // Abort on 2nd WAIT cycle of step 5 (cycle 2+5*6+3).
        d0 = done_cnt;
        run(3, 2, 3, -1, 2 + 5 * STEP_CY + 3, -1, dc);
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_pe_rst", bus.pe_rst, 1);
        chk("abort_done", bus.done, 0);
        repeat (70) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_stay_idle", bus.busy, 0);

        run(1, 5, 7, -1, -1, -1, dc);
        chk("k1_done_cyc", dc, 2 + 7 * STEP_CY);
        chk("k1_loads", run_loads, 7);
        chk("k1_results", res_bad(35), 0);
        @(negedge clk);

        // abort together with start in IDLE drops the command.
        e0 = err_cnt;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.k_len = K_W'(3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", bus.busy, 0);
        chk("idle_abort_pe_rst", bus.pe_rst, 0);
        chk("idle_abort_err", err_cnt, e0);

        // Async reset during FEED of step 2.
        d0 = done_cnt;
        run(3, 2, 3, -1, -1, 2 + 2 * STEP_CY + 1, dc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_done", done_cnt, d0);
        run(1, 5, 7, -1, -1, -1, dc);
        chk("post_rst_done_cyc", dc, 2 + 7 * STEP_CY);
        chk("post_rst_results", res_bad(35), 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
